// File: rtl/adc_capture_pkg.sv
// Shared types for the RFSoC converter data paths: capture FSM encoding and gpio_ctrl field layout.
package rfsoc_config;
   typedef enum logic [1:0] {CAP_IDLE, CAP_ARMED, CAP_CAPTURE, CAP_DRAIN} cap_state_t;
   localparam int CAP_ARM_BIT = 15;
   localparam int CAP_LEN_W   = 15;
endpackage

// File: rtl/adc_capture_if.sv
// ADC ingress stream and PS-bound readout stream; 'master' is the capture block side, 'slave' the environment.
interface adc_capture_if #(
   parameter int DATA_W = 256
) ();
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
   modport slave (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/adc_capture_ram.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port (1-cycle latency), no reset.
module capture_ram #(
   parameter int AW = 10,
   parameter int DW = 256
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [1<<AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/adc_capture.sv
// Triggered ADC burst capture into a local buffer, then readout to the PS with tlast.
// First readout beat 2 cycles after entering DRAIN, 1 beat/clk; readout stalls on m_axis_tready, ADC side never stalls.
module adc_capture
   import rfsoc_config::*;
#(
   parameter int mem_width = 10,
   parameter int DATA_W    = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   gpio_ctrl,
   input  logic          trigger_in,
   input  logic          select_in,
   output logic          busy,
   output logic          done,
   adc_capture_if.master axis
);
   localparam int DEPTH = 1 << mem_width;
   localparam int CNT_W = mem_width + 1;

   cap_state_t           state_q, state_d;
   logic                 arm_q, arm_rise, wr_fire, rd_issue, pop;
   logic [CAP_LEN_W-1:0] len_req;
   logic [CNT_W-1:0]     len_d, len_q, wr_cnt, rd_cnt;
   logic                 rd_pend, rd_pend_last, s_rdy;
   logic [DATA_W-1:0]    ram_q, out_dat, sp_dat;
   logic                 out_vld, out_last, sp_vld, sp_last, out_load, sp_load;
   logic [1:0]           occ;

   always_comb begin
      len_req = gpio_ctrl[CAP_LEN_W-1:0];
      len_d   = CNT_W'(DEPTH);
      if (len_req != '0 && len_req <= CAP_LEN_W'(DEPTH)) len_d = len_req[CNT_W-1:0];
   end

   assign arm_rise = gpio_ctrl[CAP_ARM_BIT] & ~arm_q;
   assign wr_fire  = (state_q == CAP_CAPTURE) && axis.s_axis_tvalid;
   assign pop      = out_vld & axis.m_axis_tready;
   // Reads in flight plus skid occupancy never exceed the two skid slots.
   assign occ      = {1'b0, out_vld} + {1'b0, sp_vld} + {1'b0, rd_pend};
   assign rd_issue = (state_q == CAP_DRAIN) && (rd_cnt != len_q) && (occ <= {1'b0, pop} + 2'd1);
   assign out_load = !out_vld || pop;
   assign sp_load  = rd_pend && (!out_load || sp_vld);

   always_comb begin
      state_d = state_q;
      case (state_q)
         CAP_IDLE:    if (arm_rise) state_d = CAP_ARMED;
         CAP_ARMED:   if (trigger_in && select_in) state_d = CAP_CAPTURE;
                      else if (!gpio_ctrl[CAP_ARM_BIT]) state_d = CAP_IDLE;
         CAP_CAPTURE: if (wr_fire && wr_cnt == len_q - 1'b1) state_d = CAP_DRAIN;
         CAP_DRAIN:   if (pop && out_last) state_d = CAP_IDLE;
         default:     state_d = CAP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= CAP_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm_q        <= 1'b0;
         s_rdy        <= 1'b0;
         done         <= 1'b0;
         len_q        <= '0;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         out_vld      <= 1'b0;
         out_last     <= 1'b0;
         sp_vld       <= 1'b0;
         sp_last      <= 1'b0;
      end else begin
         arm_q        <= gpio_ctrl[CAP_ARM_BIT];
         s_rdy        <= 1'b1;
         done         <= (state_q == CAP_DRAIN) && pop && out_last;
         if (state_q == CAP_IDLE && arm_rise) len_q <= len_d;
         if (state_q == CAP_ARMED) wr_cnt <= '0;
         else if (wr_fire)         wr_cnt <= wr_cnt + 1'b1;
         if (state_q != CAP_DRAIN) rd_cnt <= '0;
         else if (rd_issue)        rd_cnt <= rd_cnt + 1'b1;
         rd_pend      <= rd_issue;
         rd_pend_last <= (rd_cnt == len_q - 1'b1);
         if (out_load) begin
            out_vld  <= sp_vld | rd_pend;
            out_last <= sp_vld ? sp_last : rd_pend_last;
         end
         if (sp_load) begin
            sp_vld  <= 1'b1;
            sp_last <= rd_pend_last;
         end else if (out_load) begin
            sp_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (out_load) out_dat <= sp_vld ? sp_dat : ram_q;
      if (sp_load)  sp_dat  <= ram_q;
   end

   capture_ram #(.AW(mem_width), .DW(DATA_W)) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wr_cnt[mem_width-1:0]),
      .wdata (axis.s_axis_tdata),
      .re    (rd_issue),
      .raddr (rd_cnt[mem_width-1:0]),
      .rdata (ram_q)
   );

   assign axis.s_axis_tready = s_rdy;
   assign axis.m_axis_tdata  = out_dat;
   assign axis.m_axis_tvalid = out_vld;
   assign axis.m_axis_tlast  = out_last;
   assign busy               = (state_q != CAP_IDLE);
endmodule
